booth_mul_seq: RTL and testbench

Sequential, parametrised radix-4 Booth multiplier for the datapath's MUL instruction. It replaces the purely combinational multiplier with a start/done handshaked unit that retires one Booth digit per clock, which shortens the critical path. It supports signed and unsigned operands and any even operand width. It sits between the operand registers and the HI/LO result registers, and the control unit sequences it.

---
 rtl/mul_pkg.sv | 32 +++
 rtl/booth_mul_seq_recode.sv | 30 +++
 rtl/booth_mul_seq.sv | 100 ++++++++++
 tb/tb_booth_mul_seq.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared encodings for the sequential radix-4 Booth multiplier.
// Holds the FSM states and the Booth digit-select decode.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_sel_e;

    // Window is {b[2i+1], b[2i], b[2i-1]}
    function automatic booth_sel_e booth_sel(input logic [2:0] win);
        booth_sel_e s;
        unique case (win)
            3'b001, 3'b010: s = POS1;
            3'b011:         s = POS2;
            3'b100:         s = NEG2;
            3'b101, 3'b110: s = NEG1;
            default:        s = ZERO;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/booth_mul_seq_recode.sv
// booth_r4_recode: turns one radix-4 Booth window and the extended
// multiplicand into the signed addend for that digit.
module booth_r4_recode
    import mul_pkg::*;
#(
    parameter int ACC = 66
) (
    input  logic [2:0]     win,
    input  logic [ACC-1:0] m,
    output logic [ACC-1:0] addend
);

    booth_sel_e sel;
    logic [ACC-1:0] m2;

    assign sel = booth_sel(win);
    assign m2  = m << 1;

    always_comb begin
        addend = '0;
        unique case (sel)
            POS1:    addend = m;
            POS2:    addend = m2;
            NEG1:    addend = -m;
            NEG2:    addend = -m2;
            default: addend = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: start/done handshaked radix-4 Booth multiplier,
// one digit per clock, signed or unsigned operands.
module booth_mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int N   = WIDTH / 2 + 1;
    localparam int ACC = 2 * WIDTH + 2;
    localparam int MW  = WIDTH + 3;
    localparam int CW  = $clog2(N + 1);

    state_e         state;
    state_e         state_n;
    logic [ACC-1:0] mcand;
    logic [MW-1:0]  mplier;
    logic [ACC-1:0] acc;
    logic [CW-1:0]  cnt;
    logic [ACC-1:0] addend;
    logic [ACC-1:0] sum;
    logic [ACC-1:0] a_ext;
    logic [MW-1:0]  b_ext;
    logic           load;
    logic           last;

    // Extra extension digit makes unsigned operands exact
    assign a_ext = {{(ACC-WIDTH){signed_mode & a[WIDTH-1]}}, a};
    assign b_ext = {{2{signed_mode & b[WIDTH-1]}}, b, 1'b0};

    assign last = (cnt == CW'(N - 1));
    assign sum  = acc + addend;

    booth_r4_recode #(
        .ACC(ACC)
    ) u_recode (
        .win   (mplier[2:0]),
        .m     (mcand),
        .addend(addend)
    );

    always_comb begin
        state_n = state;
        load    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = CALC;
                    load    = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            CALC: begin
                if (last) state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            state <= state_n;
            busy  <= (state_n == CALC);
            done  <= (state_n == DONE);
            if (load) begin
                mcand  <= a_ext;
                mplier <= b_ext;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == CALC) begin
                acc    <= sum;
                mcand  <= mcand << 2;
                mplier <= mplier >> 2;
                cnt    <= cnt + CW'(1);
                if (last) prod <= sum[2*WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed scenario checks for booth_mul_seq
// at WIDTH=32 plus one WIDTH=8 boundary case.
module tb_booth_mul_seq;

    logic        clk;
    logic        clr;
    logic        start;
    logic        signed_mode;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] prod;

    logic        start8;
    logic        sm8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [15:0] prod8;

    int n_checks;
    int n_fail;

    booth_mul_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .signed_mode(signed_mode),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .prod       (prod)
    );

    booth_mul_seq #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .clr        (clr),
        .start      (start8),
        .signed_mode(sm8),
        .a          (a8),
        .b          (b8),
        .busy       (busy8),
        .done       (done8),
        .prod       (prod8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request so that it is sampled at the next rising edge,
    // then return #1 after that edge (cycle 1) with start low.
    task automatic issue(input logic sm, input logic [31:0] x,
                         input logic [31:0] y);
        @(negedge clk);
        signed_mode = sm;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called in cycle 1; returns the cycle index in which done was seen
    // (0 on timeout) and the number of busy cycles before it.
    task automatic wait_done(output int cyc, output int bcnt);
        cyc = 0;
        bcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                cyc = k;
                break;
            end
            if (busy) bcnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        clr = 1'b1;
        #3;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || prod !== 64'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b prod=%h want 0 0 0",
                     busy, done, prod);
        end
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_vec(input string name, input logic sm,
                            input logic [31:0] x, input logic [31:0] y,
                            input logic [63:0] exp);
        int cyc;
        int bcnt;
        issue(sm, x, y);
        wait_done(cyc, bcnt);
        n_checks++;
        if (prod !== exp) begin
            n_fail++;
            $display("FAIL %s prod: got %h want %h", name, prod, exp);
        end
        n_checks++;
        if (cyc !== 18 || bcnt !== 17) begin
            n_fail++;
            $display("FAIL %s timing: done cycle %0d busy %0d want 18 17",
                     name, cyc, bcnt);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || prod !== exp) begin
            n_fail++;
            $display("FAIL %s hold: done=%b prod=%h want 0 %h",
                     name, done, prod, exp);
        end
    endtask

    task automatic test_ignore;
        int cyc;
        int bcnt;
        issue(1'b0, 32'd1234, 32'd5678);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        a = 32'hDEADBEEF;
        b = 32'h12345678;
        signed_mode = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, bcnt);
        n_checks++;
        if (prod !== 64'd7006652 || cyc !== 14) begin
            n_fail++;
            $display("FAIL ignore: prod=%h cyc=%0d want %h 14",
                     prod, cyc, 64'd7006652);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int cyc;
        int bcnt;
        issue(1'b0, 32'd100, 32'd200);
        wait_done(cyc, bcnt);
        n_checks++;
        if (prod !== 64'd20000 || cyc !== 18) begin
            n_fail++;
            $display("FAIL b2b first: prod=%h cyc=%0d want %h 18",
                     prod, cyc, 64'd20000);
        end
        start = 1'b1;
        signed_mode = 1'b1;
        a = 32'hFFFFFFFB;
        b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b restart: busy=%b done=%b want 1 0",
                     busy, done);
        end
        wait_done(cyc, bcnt);
        n_checks++;
        if (prod !== 64'hFFFFFFFFFFFFFFD3 || cyc !== 18 || bcnt !== 17) begin
            n_fail++;
            $display("FAIL b2b second: prod=%h cyc=%0d busy=%0d want %h 18 17",
                     prod, cyc, bcnt, 64'hFFFFFFFFFFFFFFD3);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_clr;
        int cyc;
        int bcnt;
        bit seen;
        issue(1'b0, 32'd77777, 32'd99);
        repeat (4) @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || prod !== 64'd0) begin
            n_fail++;
            $display("FAIL clr async: busy=%b done=%b prod=%h want 0 0 0",
                     busy, done, prod);
        end
        @(negedge clk);
        clr = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL clr discard: activity after clr got %b want 0",
                     seen);
        end
        issue(1'b0, 32'd5, 32'd6);
        wait_done(cyc, bcnt);
        n_checks++;
        if (prod !== 64'd30 || cyc !== 18) begin
            n_fail++;
            $display("FAIL clr restart: prod=%h cyc=%0d want %h 18",
                     prod, cyc, 64'd30);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_width8;
        int cyc;
        cyc = 0;
        @(negedge clk);
        sm8 = 1'b0;
        a8 = 8'h80;
        b8 = 8'hFF;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (done8) begin
                cyc = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (prod8 !== 16'h7F80 || cyc !== 6) begin
            n_fail++;
            $display("FAIL w8 unsigned: prod=%h cyc=%0d want 7f80 6",
                     prod8, cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        int cyc;
        int bcnt;
        logic [31:0] x;
        logic [31:0] y;
        logic sm;
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic [63:0] exp;
        for (int i = 0; i < 200; i++) begin
            x = $urandom();
            y = $urandom();
            sm = 1'($urandom_range(0, 1));
            if (sm) begin
                sx = {{32{x[31]}}, x};
                sy = {{32{y[31]}}, y};
            end else begin
                sx = {32'd0, x};
                sy = {32'd0, y};
            end
            exp = 64'(sx * sy);
            issue(sm, x, y);
            wait_done(cyc, bcnt);
            @(posedge clk);
            #1;
            n_checks++;
            if (prod !== exp || cyc !== 18 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL rand %0d: sm=%b a=%h b=%h prod=%h want %h cyc=%0d",
                         i, sm, x, y, prod, exp, cyc);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        start = 1'b0;
        signed_mode = 1'b0;
        a = '0;
        b = '0;
        start8 = 1'b0;
        sm8 = 1'b0;
        a8 = '0;
        b8 = '0;
        test_reset();
        test_vec("neg7x3", 1'b1, 32'hFFFFFFF9, 32'd3,
                 64'hFFFFFFFFFFFFFFEB);
        test_vec("ones_u", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 64'hFFFFFFFE00000001);
        test_vec("ones_s", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 64'h0000000000000001);
        test_vec("minmin_s", 1'b1, 32'h80000000, 32'h80000000,
                 64'h4000000000000000);
        test_vec("maxmin_s", 1'b1, 32'h7FFFFFFF, 32'h80000000,
                 64'hC000000080000000);
        test_width8();
        test_ignore();
        test_back_to_back();
        test_clr();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
